axi4_lite_register_bridge: RTL

AXI4_LITE_REGISTER_BRIDGE -- requirements
Module: axi4_lite_register_bridge

---
 rtl/axi4_lite_register_bridge.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/axi4_lite_register_bridge.sv
// AXI4-Lite slave exposing a small bank of word-wide registers.
// Writes land in register_out (byte-strobed). Reads return the live register_in bank.
// Each committed write pulses wr_en for one cycle and each accepted read pulses rd_en for one cycle.
// The write and read channels run as two independent two-state machines.
module axi4_lite_register_bridge #(
  parameter int N       = 4,
  parameter int CLOG2_W = 2,
  parameter int W       = 2**CLOG2_W,
  parameter int A       = 32
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [A-1:0]         awaddr,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [8*N-1:0]       wdata,
  input  logic [N-1:0]         wstrb,
  input  logic                 wvalid,
  output logic                 wready,
  output logic [1:0]           bresp,
  output logic                 bvalid,
  input  logic                 bready,
  input  logic [A-1:0]         araddr,
  input  logic                 arvalid,
  output logic                 arready,
  output logic [8*N-1:0]       rdata,
  output logic [1:0]           rresp,
  output logic                 rvalid,
  input  logic                 rready,
  input  logic [W*8*N-1:0]     register_in,
  output logic [W*8*N-1:0]     register_out,
  output logic [W-1:0]         wr_en,
  output logic [W-1:0]         rd_en,
  output logic [8*N-1:0]       reg_wdata
);

  localparam int DW = 8 * N;
  localparam int LB = (N == 8) ? 3 : 2;
  localparam int IH = CLOG2_W + LB;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Only 4-byte and 8-byte words are supported; any other width is flagged at run time.
  if (!(N == 4 || N == 8)) begin : g_bad_n
    always_ff @(posedge aclk) begin
      assert (N == 4 || N == 8) else $error("axi4_lite_register_bridge: N must be 4 or 8");
    end
  end

  // An address is in range only when every bit above the word index is clear.
  function automatic logic addr_in_range(input logic [A-1:0] addr);
    return (addr >> IH) == '0;
  endfunction

  function automatic logic [CLOG2_W-1:0] addr_word(input logic [A-1:0] addr);
    return addr[IH-1:LB];
  endfunction

  function automatic logic [W-1:0] word_onehot(input logic [CLOG2_W-1:0] idx);
    return W'(1) << idx;
  endfunction

  logic [0:0]         w_state;
  logic [0:0]         r_state;
  logic               aw_got_p0;
  logic               w_got_p0;
  logic [A-1:0]       aw_addr_p0;
  logic [DW-1:0]      wdata_p0;
  logic [N-1:0]       wstrb_p0;

  logic               aw_fire;
  logic               w_fire;
  logic               ar_fire;
  logic               commit;
  logic [A-1:0]       cmt_addr;
  logic [DW-1:0]      cmt_data;
  logic [N-1:0]       cmt_strb;
  logic [CLOG2_W-1:0] cmt_idx;
  logic               cmt_ok;
  logic [CLOG2_W-1:0] rd_idx;
  logic               rd_ok;

  // Ready outputs come from state only, and they are held low while reset is asserted.
  assign awready = !areset && (w_state == W_IDLE) && !aw_got_p0;
  assign wready  = !areset && (w_state == W_IDLE) && !w_got_p0;
  assign arready = !areset && (r_state == R_IDLE);

  // Commit takes the AW/W half that arrives this cycle, or the half held from an earlier cycle.
  always_comb begin
    aw_fire  = awvalid && awready;
    w_fire   = wvalid && wready;
    ar_fire  = arvalid && arready;
    commit   = (aw_got_p0 || aw_fire) && (w_got_p0 || w_fire);
    cmt_addr = aw_fire ? awaddr : aw_addr_p0;
    cmt_data = w_fire ? wdata : wdata_p0;
    cmt_strb = w_fire ? wstrb : wstrb_p0;
    cmt_idx  = addr_word(cmt_addr);
    cmt_ok   = addr_in_range(cmt_addr);
    rd_idx   = addr_word(araddr);
    rd_ok    = addr_in_range(araddr);
  end

  // Holding registers for whichever of AW/W is accepted first (data path, not reset).
  always_ff @(posedge aclk) begin
    if (aw_fire) begin
      aw_addr_p0 <= awaddr;
    end
    if (w_fire) begin
      wdata_p0 <= wdata;
      wstrb_p0 <= wstrb;
    end
  end

  // Write channel FSM: collect AW and W, commit the bytes, then hold B until it is accepted.
  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state      <= W_IDLE;
      aw_got_p0    <= 1'b0;
      w_got_p0     <= 1'b0;
      bvalid       <= 1'b0;
      bresp        <= RESP_OKAY;
      wr_en        <= '0;
      reg_wdata    <= '0;
      register_out <= '0;
    end else begin
      wr_en <= '0;
      if (commit) begin
        aw_got_p0 <= 1'b0;
        w_got_p0  <= 1'b0;
        w_state   <= W_RESP;
        bvalid    <= 1'b1;
        if (cmt_ok) begin
          bresp     <= RESP_OKAY;
          wr_en     <= word_onehot(cmt_idx);
          reg_wdata <= cmt_data;
          for (int k = 0; k < N; k++) begin
            if (cmt_strb[k]) begin
              register_out[cmt_idx*DW + k*8 +: 8] <= cmt_data[k*8 +: 8];
            end
          end
        end else begin
          bresp <= RESP_SLVERR;
        end
      end else begin
        if (aw_fire) begin
          aw_got_p0 <= 1'b1;
        end
        if (w_fire) begin
          w_got_p0 <= 1'b1;
        end
        if (w_state == W_RESP && bready) begin
          bvalid  <= 1'b0;
          w_state <= W_IDLE;
        end
      end
    end
  end

  // Read channel FSM: sample register_in on AR acceptance, then hold R until it is accepted.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= R_IDLE;
      rvalid  <= 1'b0;
      rresp   <= RESP_OKAY;
      rdata   <= '0;
      rd_en   <= '0;
    end else begin
      rd_en <= '0;
      if (ar_fire) begin
        r_state <= R_DATA;
        rvalid  <= 1'b1;
        if (rd_ok) begin
          rresp <= RESP_OKAY;
          rdata <= register_in[rd_idx*DW +: DW];
          rd_en <= word_onehot(rd_idx);
        end else begin
          rresp <= RESP_SLVERR;
          rdata <= '0;
        end
      end else if (r_state == R_DATA && rready) begin
        rvalid  <= 1'b0;
        r_state <= R_IDLE;
      end
    end
  end

endmodule
